mont_mul_var: RTL and testbench

Radix-2 bit-serial Montgomery multiplier that computes A*B*2^(-32*len) mod N. The operand length `len` (in 32-bit words) is selected at run time, up to MAX_WORDS.
- Optional squaring mode (B = A) skips the B fetch.
- Operands are fetched from memory and the result is written back through the core LSU port.
- Every LSU access, including writes, is acknowledged by lsu_done.
- Sits beside the ALU as a multi-cycle coprocessor. The core stalls on `busy`.

---
 rtl/mont_mul_pkg.sv | 28 ++
 rtl/mont_mul_dp.sv | 65 ++++++
 rtl/mont_mul_var.sv | 157 +++++++++++++++
 tb/tb_mont_mul_var.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/mont_mul_pkg.sv
// Shared definitions for the bit-serial Montgomery multiplier: FSM encoding,
// fetch phases, LSU access type and the run-time length field width.
package mont_mul_pkg;

   typedef enum logic [2:0] {
      IDLE,
      FETCH,
      ADD_B,
      ADD_N,
      SUB,
      STORE,
      FIN
   } state_e;

   typedef enum logic [1:0] {
      PH_A,
      PH_B,
      PH_N
   } phase_e;

   localparam logic [1:0] DATA_WORD = 2'd2;

   // len must be able to express MAX_WORDS itself, hence the extra bit
   function automatic int len_width(input int max_words);
      return $clog2(max_words) + 1;
   endfunction

endpackage

// File: rtl/mont_mul_dp.sv
// Operand registers A/B/N, accumulator M and the single shared adder that
// serves M+B, M+N and the final M-N (as M + ~N + 1).
module mont_mul_dp #(
   parameter int  MAX_WORDS = 8,
   localparam int MAX_BITS  = 32 * MAX_WORDS,
   localparam int IW        = $clog2(MAX_WORDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                clr,
   input  logic                wr_a,
   input  logic                wr_b,
   input  logic                wr_n,
   input  logic [IW-1:0]       wr_idx,
   input  logic [31:0]         wr_data,
   input  logic                add_b,
   input  logic                add_n,
   input  logic                sub,
   output logic [MAX_BITS-1:0] m_o
);

   logic [MAX_BITS-1:0] a_q, b_q, n_q;
   logic [MAX_BITS+1:0] m_q;
   logic [MAX_BITS+1:0] opb;
   logic [MAX_BITS+2:0] sum;

   always_comb begin
      opb = {2'b00, b_q};
      if (sub)
         opb = ~{2'b00, n_q};
      else if (add_n)
         opb = {2'b00, n_q};
   end

   // Top bit of sum is the carry-out; during SUB it means M >= N
   assign sum = {1'b0, m_q} + {1'b0, opb} + {{(MAX_BITS+2){1'b0}}, sub};
   assign m_o = m_q[MAX_BITS-1:0];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q <= '0;
         b_q <= '0;
         n_q <= '0;
         m_q <= '0;
      end else if (clr) begin
         a_q <= '0;
         b_q <= '0;
         n_q <= '0;
         m_q <= '0;
      end else begin
         if (wr_a) a_q[{wr_idx, 5'd0} +: 32] <= wr_data;
         if (wr_b) b_q[{wr_idx, 5'd0} +: 32] <= wr_data;
         if (wr_n) n_q[{wr_idx, 5'd0} +: 32] <= wr_data;
         if (add_b && a_q[0])
            m_q <= sum[MAX_BITS+1:0];
         if (add_n) begin
            m_q <= m_q[0] ? sum[MAX_BITS+2:1] : (m_q >> 1);
            a_q <= a_q >> 1;
         end
         if (sub && sum[MAX_BITS+2])
            m_q <= sum[MAX_BITS+1:0];
      end
   end

endmodule

// File: rtl/mont_mul_var.sv
// Run-time length Montgomery multiplier coprocessor: FSM, operand fetch and
// result store over the core LSU port; arithmetic lives in mont_mul_dp.
module mont_mul_var
   import mont_mul_pkg::*;
#(
   parameter int  MAX_WORDS = 8,
   localparam int MAX_BITS  = 32 * MAX_WORDS,
   localparam int LW        = len_width(MAX_WORDS)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                start,
   input  logic [31:0]         A_addr,
   input  logic [31:0]         B_addr,
   input  logic [31:0]         N_addr,
   input  logic [31:0]         res_addr,
   input  logic [LW-1:0]       len,
   input  logic                square,
   output logic                lsu_ren,
   output logic                lsu_wen,
   output logic [1:0]          lsu_type,
   output logic [31:0]         lsu_addr_base,
   output logic [31:0]         lsu_addr_offset,
   input  logic                lsu_done,
   input  logic [31:0]         lsu_rdata,
   output logic [31:0]         lsu_wdata,
   output logic [MAX_BITS-1:0] result,
   output logic                busy,
   output logic                err,
   output logic                done
);

   localparam int IW = $clog2(MAX_WORDS);
   localparam int BW = LW + 5;

   state_e        state_q;
   phase_e        phase_q;
   logic [31:0]   a_base_q, b_base_q, n_base_q, r_base_q;
   logic [LW-1:0] len_q;
   logic          square_q;
   logic [IW-1:0] word_q;
   logic [BW-1:0] bit_q;
   logic          done_q, err_q;
   logic          last_word, last_bit, accept, wr_en;

   assign accept    = (state_q == IDLE) && start;
   assign wr_en     = (state_q == FETCH) && lsu_done;
   assign last_word = ({1'b0, word_q} == (len_q - LW'(1)));
   assign last_bit  = (bit_q == ({len_q, 5'd0} - BW'(1)));

   mont_mul_dp #(.MAX_WORDS(MAX_WORDS)) u_dp (
      .clk     (clk),
      .rst_n   (rst_n),
      .clr     (accept),
      .wr_a    (wr_en && (phase_q == PH_A)),
      .wr_b    (wr_en && ((phase_q == PH_B) || ((phase_q == PH_A) && square_q))),
      .wr_n    (wr_en && (phase_q == PH_N)),
      .wr_idx  (word_q),
      .wr_data (lsu_rdata),
      .add_b   (state_q == ADD_B),
      .add_n   (state_q == ADD_N),
      .sub     (state_q == SUB),
      .m_o     (result)
   );

   // Access strobes decode straight from state so reset drops them at once
   assign lsu_ren         = (state_q == FETCH);
   assign lsu_wen         = (state_q == STORE);
   assign lsu_type        = DATA_WORD;
   assign lsu_addr_offset = 32'({word_q, 2'b00});
   assign lsu_wdata       = result[{word_q, 5'd0} +: 32];
   assign busy            = (state_q != IDLE);
   assign done            = done_q;
   assign err             = err_q;

   always_comb begin
      lsu_addr_base = n_base_q;
      if (state_q == STORE)
         lsu_addr_base = r_base_q;
      else if (phase_q == PH_A)
         lsu_addr_base = a_base_q;
      else if (phase_q == PH_B)
         lsu_addr_base = b_base_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q  <= IDLE;
         phase_q  <= PH_A;
         a_base_q <= '0;
         b_base_q <= '0;
         n_base_q <= '0;
         r_base_q <= '0;
         len_q    <= '0;
         square_q <= 1'b0;
         word_q   <= '0;
         bit_q    <= '0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: if (start) begin
               a_base_q <= A_addr;
               b_base_q <= B_addr;
               n_base_q <= N_addr;
               r_base_q <= res_addr;
               len_q    <= len;
               square_q <= square;
               word_q   <= '0;
               bit_q    <= '0;
               phase_q  <= PH_A;
               err_q    <= 1'b0;
               if ((len == '0) || (len > LW'(MAX_WORDS))) begin
                  state_q <= FIN;
                  err_q   <= 1'b1;
                  done_q  <= 1'b1;
               end else begin
                  state_q <= FETCH;
               end
            end
            FETCH: if (lsu_done) begin
               if (last_word) begin
                  word_q <= '0;
                  case (phase_q)
                     PH_A:    phase_q <= square_q ? PH_N : PH_B;
                     PH_B:    phase_q <= PH_N;
                     default: state_q <= ADD_B;
                  endcase
               end else begin
                  word_q <= word_q + IW'(1);
               end
            end
            ADD_B: state_q <= ADD_N;
            ADD_N: begin
               bit_q   <= bit_q + BW'(1);
               state_q <= last_bit ? SUB : ADD_B;
            end
            SUB: begin
               word_q  <= '0;
               state_q <= STORE;
            end
            STORE: if (lsu_done) begin
               if (last_word) begin
                  state_q <= FIN;
                  done_q  <= 1'b1;
               end else begin
                  word_q <= word_q + IW'(1);
               end
            end
            FIN:     state_q <= IDLE;
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mont_mul_var.sv
// Directed bench for mont_mul_var with a behavioural LSU memory that answers
// after a programmable random delay and records access statistics.
module tb_mont_mul_var;

   localparam int MAX_WORDS = 8;
   localparam int MAX_BITS  = 32 * MAX_WORDS;
   localparam logic [31:0] A_AD = 32'h100, B_AD = 32'h200, N_AD = 32'h300, R_AD = 32'h400;

   logic                clk = 1'b0;
   logic                rst_n = 1'b0;
   logic                start = 1'b0;
   logic [31:0]         A_addr = A_AD, B_addr = B_AD, N_addr = N_AD, res_addr = R_AD;
   logic [3:0]          len = 4'd1;
   logic                square = 1'b0;
   logic                lsu_ren, lsu_wen;
   logic [1:0]          lsu_type;
   logic [31:0]         lsu_addr_base, lsu_addr_offset, lsu_wdata;
   logic                lsu_done = 1'b0;
   logic [31:0]         lsu_rdata = '0;
   logic [MAX_BITS-1:0] result;
   logic                busy, err, done;

   logic [31:0] mem [0:511];
   int errors = 0, checks = 0;
   int max_delay = 0, wait_left = 0;
   int reads = 0, b_reads = 0, writes = 0, acc_cycles = 0, stab_err = 0;
   logic        prev_act = 1'b0;
   logic [31:0] prev_base = '0, prev_off = '0, prev_wdata = '0;

   always #5 clk = ~clk;

   mont_mul_var #(.MAX_WORDS(MAX_WORDS)) dut (
      .clk(clk), .rst_n(rst_n), .start(start),
      .A_addr(A_addr), .B_addr(B_addr), .N_addr(N_addr), .res_addr(res_addr),
      .len(len), .square(square),
      .lsu_ren(lsu_ren), .lsu_wen(lsu_wen), .lsu_type(lsu_type),
      .lsu_addr_base(lsu_addr_base), .lsu_addr_offset(lsu_addr_offset),
      .lsu_done(lsu_done), .lsu_rdata(lsu_rdata), .lsu_wdata(lsu_wdata),
      .result(result), .busy(busy), .err(err), .done(done)
   );

   // LSU responder: acts on the falling edge, DUT samples lsu_done on the rising edge
   always @(negedge clk) begin
      int idx;
      if (lsu_done) begin
         lsu_done  = 1'b0;
         prev_act  = 1'b0;
         wait_left = $urandom_range(max_delay, 0);
      end
      if (!(lsu_ren || lsu_wen)) begin
         prev_act  = 1'b0;
         wait_left = $urandom_range(max_delay, 0);
      end else begin
         acc_cycles++;
         if (prev_act && (lsu_addr_base !== prev_base || lsu_addr_offset !== prev_off ||
                          (lsu_wen && lsu_wdata !== prev_wdata)))
            stab_err++;
         prev_act   = 1'b1;
         prev_base  = lsu_addr_base;
         prev_off   = lsu_addr_offset;
         prev_wdata = lsu_wdata;
         if (wait_left == 0) begin
            idx = int'(((lsu_addr_base + lsu_addr_offset) >> 2) & 32'h1FF);
            lsu_done = 1'b1;
            if (lsu_ren) begin
               lsu_rdata = mem[idx];
               reads++;
               if (lsu_addr_base == B_AD) b_reads++;
            end else begin
               mem[idx] = lsu_wdata;
               writes++;
            end
         end else begin
            wait_left--;
         end
      end
   end

   task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
      checks++;
      $display("check %s: observed=%0h expected=%0h", tag, obs, exp);
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_mem();
      for (int i = 0; i < 512; i++) mem[i] = (i >= 256) ? 32'hDEADBEEF : 32'h0;
      reads = 0; b_reads = 0; writes = 0; acc_cycles = 0;
   endtask

   // cyc counts cycles after the start cycle until the cycle where done is seen
   task automatic run(input logic [3:0] l, input logic sq, input bit poke, output int cyc);
      @(negedge clk);
      len = l; square = sq; start = 1'b1; cyc = 0;
      while (1) begin
         @(negedge clk);
         cyc++;
         start = poke && (cyc % 37 == 5) && !done;
         len   = start ? 4'd0 : l;
         if (done) break;
         if (cyc > 5000) begin
            check("done_timeout", 256'(cyc), 256'(0));
            break;
         end
      end
      start = 1'b0;
   endtask

   initial begin
      int cyc;
      clear_mem();
      repeat (2) @(negedge clk);
      check("reset_busy", 256'(busy), 256'(0));
      check("reset_done_err_ren_wen", 256'({done, err, lsu_ren, lsu_wen}), 256'(0));
      check("reset_result", 256'(result), 256'(0));
      rst_n = 1'b1;

      // 1: 5*7*2^-32 mod 13 = 1
      clear_mem();
      mem[64] = 32'd5; mem[128] = 32'd7; mem[192] = 32'd13;
      run(4'd1, 1'b0, 1'b0, cyc);
      check("t1_latency", 256'(cyc), 256'(4 + 64 + 2));
      check("t1_err", 256'(err), 256'(0));
      check("t1_mem", 256'(mem[256]), 256'(1));
      check("t1_result", 256'(result), 256'(1));
      check("t1_reads", 256'(reads), 256'(3));

      // 2: square 5*5*2^-32 mod 13 = 10
      clear_mem();
      mem[64] = 32'd5; mem[128] = 32'd7; mem[192] = 32'd13;
      run(4'd1, 1'b1, 1'b0, cyc);
      check("t2_result", 256'(result), 256'(10));
      check("t2_mem", 256'(mem[256]), 256'(10));
      check("t2_reads", 256'(reads), 256'(2));
      check("t2_b_reads", 256'(b_reads), 256'(0));
      check("t2_latency", 256'(cyc), 256'(3 + 64 + 2));

      // 3: 59*59*R^-1 with R mod N = 59 gives 59
      clear_mem();
      mem[64] = 32'd59; mem[128] = 32'd59;
      mem[192] = 32'hFFFFFFC5; mem[193] = 32'hFFFFFFFF;
      run(4'd2, 1'b0, 1'b0, cyc);
      check("t3_mem0", 256'(mem[256]), 256'(59));
      check("t3_mem1", 256'(mem[257]), 256'(0));
      check("t3_result", 256'(result), 256'(59));
      check("t3_latency", 256'(cyc), 256'(8 + 128 + 2));

      // 4: illegal lengths
      clear_mem();
      run(4'd0, 1'b0, 1'b0, cyc);
      check("t4_len0_latency", 256'(cyc), 256'(1));
      check("t4_len0_err", 256'(err), 256'(1));
      run(4'(MAX_WORDS + 1), 1'b0, 1'b0, cyc);
      check("t4_lenbig_latency", 256'(cyc), 256'(1));
      check("t4_lenbig_err", 256'(err), 256'(1));
      check("t4_no_access", 256'(acc_cycles), 256'(0));

      // 5: A=0 at full length with random LSU delays and ignored start pulses
      clear_mem();
      max_delay = 5; stab_err = 0;
      for (int i = 0; i < MAX_WORDS; i++) begin
         mem[128 + i] = $urandom;
         mem[192 + i] = $urandom | ((i == 0) ? 32'h1 : 32'h0) | ((i == MAX_WORDS - 1) ? 32'h80000000 : 32'h0);
      end
      run(4'(MAX_WORDS), 1'b0, 1'b1, cyc);
      check("t5_err", 256'(err), 256'(0));
      check("t5_result", 256'(result), 256'(0));
      for (int i = 0; i < MAX_WORDS; i++) check($sformatf("t5_mem%0d", i), 256'(mem[256 + i]), 256'(0));
      check("t5_stable", 256'(stab_err), 256'(0));
      check("t5_reads_writes", 256'({reads[15:0], writes[15:0]}), 256'({16'(3 * MAX_WORDS), 16'(MAX_WORDS)}));
      max_delay = 0;

      // 6: reset during STORE word 1 of case 3, then a clean case 1
      clear_mem();
      mem[64] = 32'd59; mem[128] = 32'd59;
      mem[192] = 32'hFFFFFFC5; mem[193] = 32'hFFFFFFFF;
      @(negedge clk);
      len = 4'd2; square = 1'b0; start = 1'b1;
      cyc = 0;
      @(negedge clk);
      start = 1'b0;
      while (!(lsu_wen && lsu_addr_offset == 32'd4) && cyc < 1000) begin
         @(negedge clk);
         cyc++;
      end
      check("t6_reached_store1", 256'(cyc < 1000), 256'(1));
      rst_n = 1'b0;
      #1;
      check("t6_wen", 256'(lsu_wen), 256'(0));
      check("t6_busy", 256'(busy), 256'(0));
      check("t6_done", 256'(done), 256'(0));
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      clear_mem();
      mem[64] = 32'd5; mem[128] = 32'd7; mem[192] = 32'd13;
      run(4'd1, 1'b0, 1'b0, cyc);
      check("t6_rerun_result", 256'(result), 256'(1));
      check("t6_rerun_mem", 256'(mem[256]), 256'(1));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
